// File: rtl/mag_peak_detect.sv
// mag_peak_detect
// Packet-wise peak finder for a tlast-delimited stream of unsigned magnitudes.
// Each input packet produces one single-beat result word:
//   o_tdata = {sat, above, peak_idx[IDX_WIDTH-1:0], peak_val[WIDTH-1:0]}
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           synchronous flush, same effect as reset
//   threshold       detection threshold, sampled on the accepted tlast beat
//   i_tdata/i_tlast/i_tvalid/i_tready   magnitude input stream
//   o_tdata/o_tlast/o_tvalid/o_tready   single-beat result stream
module mag_peak_detect #(
    parameter int WIDTH     = 16,
    parameter int IDX_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             threshold,
    input  logic [WIDTH-1:0]             i_tdata,
    input  logic                         i_tlast,
    input  logic                         i_tvalid,
    output logic                         i_tready,
    output logic [WIDTH+IDX_WIDTH+1:0]   o_tdata,
    output logic                         o_tlast,
    output logic                         o_tvalid,
    input  logic                         o_tready
);

    localparam int                   OUT_W   = WIDTH + IDX_WIDTH + 2;
    localparam logic [IDX_WIDTH-1:0] IDX_MAX = '1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t state, state_nxt;

    logic                 flush;
    logic                 in_fire;
    logic                 out_fire;

    // Running accumulation for the packet in progress
    logic [WIDTH-1:0]     peak_val;
    logic [IDX_WIDTH-1:0] peak_idx;
    logic [IDX_WIDTH-1:0] cnt;
    logic                 sat;
    logic                 first_beat;

    // Candidate peak including the beat currently presented
    logic                 new_peak;
    logic [WIDTH-1:0]     cand_val;
    logic [IDX_WIDTH-1:0] cand_idx;
    logic                 cand_sat;
    logic                 cand_above;

    // Result register held during HOLD
    logic [OUT_W-1:0]     res_p1;

    // Saturating sample counter increment
    function automatic logic [IDX_WIDTH-1:0] cnt_inc(input logic [IDX_WIDTH-1:0] c);
        return (c == IDX_MAX) ? c : c + IDX_WIDTH'(1);
    endfunction

    assign flush    = reset | clear;
    assign in_fire  = i_tvalid & i_tready;
    assign out_fire = o_tvalid & o_tready;

    // ---------------- Stage p0: compare incoming beat against running peak
    always_comb begin
        // Strict greater-than keeps the earliest index on ties.
        new_peak   = first_beat | (i_tdata > peak_val);
        cand_val   = new_peak ? i_tdata : peak_val;
        // cnt never exceeds IDX_MAX, so a late peak records the saturated index.
        cand_idx   = new_peak ? (first_beat ? '0 : cnt) : peak_idx;
        cand_sat   = sat | (cnt == IDX_MAX);
        cand_above = (cand_val >= threshold);
    end

    // ---------------- Stage p1: accumulate / capture result on tlast
    always_ff @(posedge clk) begin
        if (flush) begin
            peak_val   <= '0;
            peak_idx   <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
            first_beat <= 1'b1;
            res_p1     <= '0;
        end else if (in_fire) begin
            peak_val <= cand_val;
            peak_idx <= cand_idx;
            if (i_tlast) begin
                res_p1     <= {cand_sat, cand_above, cand_idx, cand_val};
                cnt        <= '0;
                sat        <= 1'b0;
                first_beat <= 1'b1;
            end else begin
                cnt        <= cnt_inc(cnt);
                sat        <= cand_sat;
                first_beat <= 1'b0;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (flush) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (in_fire && i_tlast) state_nxt = HOLD;
            HOLD:    if (out_fire)           state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // FSM: outputs
    always_comb begin
        i_tready = 1'b0;
        o_tvalid = 1'b0;
        o_tlast  = 1'b0;
        case (state)
            ACCUM: i_tready = 1'b1;
            HOLD: begin
                o_tvalid = 1'b1;
                o_tlast  = 1'b1;
            end
            default: i_tready = 1'b1;
        endcase
    end

    assign o_tdata = res_p1;

endmodule
